// File: rtl/bitmap_pkg.sv
// Shared encodings for the bitmap controller: request opcodes, controller states
// and the bit-update rule.
package bitmap_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLR    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    CLEAR = 2'b10
  } state_t;

  function automatic logic apply_op(input op_t op, input logic old);
    logic nxt;
    nxt = old;
    case (op)
      OP_READ:   nxt = old;
      OP_SET:    nxt = 1'b1;
      OP_CLR:    nxt = 1'b0;
      OP_TOGGLE: nxt = ~old;
      default:   nxt = old;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// 1-bit simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module sdp_bram #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  logic mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bitmap_ctrl.sv
// Two-port bitmap RAM controller: round-robin arbitration, read/set/clear/toggle
// returning the old bit, full clear sweep and live set-bit count.
// Define BITMAP_CLEAR_ON_RESET_EN to run a clear sweep straight out of reset.
module bitmap_ctrl
  import bitmap_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [1:0]        req_op_0,
  input  logic [1:0]        req_op_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic              rsp_bit_0,
  output logic              rsp_bit_1,
  output logic [ADDR_W:0]   set_count
);

`ifdef BITMAP_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = RUN;
`endif

  state_t state, state_next;
  logic ptr;
  logic grant_0, grant_1, accept;
  logic [ADDR_W-1:0] acc_addr;
  op_t acc_op;

  logic              s1_valid, s1_port, s1_fwd, s1_fwd_val;
  logic [ADDR_W-1:0] s1_addr;
  op_t               s1_op;
  logic              read_val, s1_old, s1_new, s1_write;

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last, sweeping;
  logic              ram_we, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    grant_0    = 1'b0;
    grant_1    = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b0;
        if (clear_start) state_next = DRAIN;
        else begin
          grant_0 = req_valid_0 && (!req_valid_1 || !ptr);
          grant_1 = req_valid_1 && (!req_valid_0 || ptr);
        end
      end
      DRAIN:   state_next = CLEAR;
      CLEAR:   if (sweep_last) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign req_ready_0 = grant_0 && !rst;
  assign req_ready_1 = grant_1 && !rst;
  assign accept      = req_ready_0 || req_ready_1;
  assign acc_addr    = req_ready_1 ? req_addr_1 : req_addr_0;
  assign acc_op      = req_ready_1 ? op_t'(req_op_1) : op_t'(req_op_0);

  assign s1_old   = s1_fwd ? s1_fwd_val : read_val;
  assign s1_new   = apply_op(s1_op, s1_old);
  assign s1_write = s1_valid && (s1_new != s1_old);

  assign sweeping   = (state == CLEAR);
  assign sweep_last = (sweep_addr == '1);
  assign ram_we     = s1_write || sweeping;
  assign ram_waddr  = sweeping ? sweep_addr : s1_addr;
  assign ram_wdata  = sweeping ? 1'b0 : s1_new;

  // The RAM read for an op accepted now sees the pre-write value of the op
  // currently in S1, so that op's result is carried along instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_port    <= 1'b0;
      s1_addr    <= '0;
      s1_op      <= OP_READ;
      s1_fwd     <= 1'b0;
      s1_fwd_val <= 1'b0;
      ptr        <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_port    <= req_ready_1;
        s1_addr    <= acc_addr;
        s1_op      <= acc_op;
        s1_fwd     <= s1_write && (s1_addr == acc_addr);
        s1_fwd_val <= s1_new;
        ptr        <= !req_ready_1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_bit_0   <= 1'b0;
      rsp_bit_1   <= 1'b0;
    end else begin
      rsp_valid_0 <= s1_valid && !s1_port;
      rsp_valid_1 <= s1_valid && s1_port;
      rsp_bit_0   <= s1_valid && !s1_port && s1_old;
      rsp_bit_1   <= s1_valid && s1_port && s1_old;
    end
  end

  // The counter wraps back to zero on the last address, ready for the next sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_addr <= '0;
      clear_done <= 1'b0;
      set_count  <= '0;
    end else begin
      clear_done <= sweeping && sweep_last;
      if (sweeping) sweep_addr <= sweep_addr + 1'b1;
      if (sweeping && sweep_last) set_count <= '0;
      else if (s1_write) begin
        if (s1_new) set_count <= set_count + (ADDR_W+1)'(1);
        else        set_count <= set_count - (ADDR_W+1)'(1);
      end
    end
  end

  sdp_bram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (acc_addr),
    .rdata (read_val)
  );

endmodule
